// File: rtl/idelay_fine_pipe_ctrl.sv
// Stages per-lane {coarse,fine} IDELAYE2_FINEDELAY settings and applies them together with one LD pulse.
// Latency: dly_ld/dly_cntval one cycle after write accept; SET one cycle after set_req accept, then SETTLE_CYCLES+1 to done.
// Backpressure: wr_ready low outside IDLE; optional registered readback when IDELAY_PIPE_READBACK_EN is defined.
module idelay_fine_pipe_ctrl #(
    parameter int          NUM_CHN       = 8,
    parameter int          CHN_BITS      = 3,
    parameter logic [7:0]  DELAY_VALUE   = 8'h00,
    parameter int          FINE_MAX      = 4,
    parameter int          SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [CHN_BITS-1:0]    wr_chn,
    input  logic                   wr_bcast,
    input  logic [7:0]             wr_delay,
    input  logic                   set_req,
    output logic                   busy,
    output logic                   done,
    input  logic                   err_clr,
    output logic                   err_fine,
    output logic                   err_chn,
    output logic [NUM_CHN-1:0]     dly_ld,
    output logic [5*NUM_CHN-1:0]   dly_cntval,
    output logic [3*NUM_CHN-1:0]   dly_ifdly,
    output logic                   dly_set,
    output logic                   dly_rst,
    input  logic [CHN_BITS-1:0]    rd_chn,
    output logic [7:0]             rd_delay
);

    localparam logic [2:0] FINE_LIM  = FINE_MAX[2:0];
    localparam logic [7:0] SETTLE_LD = SETTLE_CYCLES[7:0] - 8'd1;

    typedef enum logic [1:0] {S_IDLE, S_SET, S_SETTLE, S_DONE} state_t;

    state_t               state, nxt;
    logic [1:0]           rel_sr;
    logic                 rel;
    logic                 wr_acc;
    logic [NUM_CHN-1:0]   lane_mask;
    logic                 chn_bad;
    logic                 fine_bad;
    logic [2:0]           fine_in;
    logic [3*NUM_CHN-1:0] stg_fine;
    logic [7:0]           cnt;

    // dly_cntval doubles as the staged coarse value; dly_ifdly is the applied fine value.
    assign rel      = rel_sr[1];
    assign dly_rst  = ~rel;
    assign wr_ready = rel && (state == S_IDLE);
    assign wr_acc   = wr_valid && wr_ready;
    assign fine_bad = wr_delay[2:0] > FINE_LIM;
    assign fine_in  = fine_bad ? FINE_LIM : wr_delay[2:0];
    assign dly_set  = (state == S_SET);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_comb begin
        lane_mask = '0;
        chn_bad   = !wr_bcast && (32'(wr_chn) >= NUM_CHN);
        for (int i = 0; i < NUM_CHN; i++) begin
            lane_mask[i] = wr_bcast || (32'(wr_chn) == i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_sr <= 2'b00;
        end else begin
            rel_sr <= {rel_sr[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (rel && set_req && !wr_acc) nxt = S_SET;
            S_SET:    nxt = (SETTLE_CYCLES == 0) ? S_DONE : S_SETTLE;
            S_SETTLE: if (cnt == 8'd0) nxt = S_DONE;
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (state == S_SET) begin
            cnt <= SETTLE_LD;
        end else if (state == S_SETTLE && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_ld     <= '0;
            dly_cntval <= {NUM_CHN{DELAY_VALUE[7:3]}};
            stg_fine   <= {NUM_CHN{DELAY_VALUE[2:0]}};
            dly_ifdly  <= {NUM_CHN{DELAY_VALUE[2:0]}};
        end else begin
            dly_ld <= wr_acc ? lane_mask : '0;
            for (int i = 0; i < NUM_CHN; i++) begin
                if (wr_acc && lane_mask[i]) begin
                    dly_cntval[5*i +: 5] <= wr_delay[7:3];
                    stg_fine[3*i +: 3]   <= fine_in;
                end
            end
            if (state == S_SET) begin
                dly_ifdly <= stg_fine;
            end
        end
    end

    // A new error in the same cycle as err_clr wins, so nothing is silently dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_fine <= 1'b0;
            err_chn  <= 1'b0;
        end else begin
            err_fine <= (err_fine && !err_clr) || (wr_acc && !chn_bad && fine_bad);
            err_chn  <= (err_chn && !err_clr) || (wr_acc && chn_bad);
        end
    end

`ifdef IDELAY_PIPE_READBACK_EN
    logic [5*NUM_CHN-1:0] app_coarse;
    logic [7:0]           rd_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            app_coarse <= {NUM_CHN{DELAY_VALUE[7:3]}};
        end else if (state == S_SET) begin
            app_coarse <= dly_cntval;
        end
    end

    always_comb begin
        rd_nxt = 8'h00;
        for (int i = 0; i < NUM_CHN; i++) begin
            if (32'(rd_chn) == i) begin
                rd_nxt = {app_coarse[5*i +: 5], dly_ifdly[3*i +: 3]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_delay <= DELAY_VALUE;
        end else begin
            rd_delay <= rd_nxt;
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^rd_chn;
    assign rd_delay  = 8'h00;
`endif

endmodule

// File: tb/tb_idelay_fine_pipe_ctrl.sv
module tb_idelay_fine_pipe_ctrl;

    localparam int NCH = 6;
    localparam int CB  = 3;
`ifdef IDELAY_PIPE_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             wr_valid;
    logic             wr_ready;
    logic [CB-1:0]    wr_chn;
    logic             wr_bcast;
    logic [7:0]       wr_delay;
    logic             set_req;
    logic             busy;
    logic             done;
    logic             err_clr;
    logic             err_fine;
    logic             err_chn;
    logic [NCH-1:0]   dly_ld;
    logic [5*NCH-1:0] dly_cntval;
    logic [3*NCH-1:0] dly_ifdly;
    logic             dly_set;
    logic             dly_rst;
    logic [CB-1:0]    rd_chn;
    logic [7:0]       rd_delay;

    int checks   = 0;
    int failures = 0;

    idelay_fine_pipe_ctrl #(
        .NUM_CHN(NCH), .CHN_BITS(CB), .DELAY_VALUE(8'h2B), .FINE_MAX(4), .SETTLE_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chn(wr_chn),
        .wr_bcast(wr_bcast), .wr_delay(wr_delay), .set_req(set_req), .busy(busy), .done(done),
        .err_clr(err_clr), .err_fine(err_fine), .err_chn(err_chn), .dly_ld(dly_ld),
        .dly_cntval(dly_cntval), .dly_ifdly(dly_ifdly), .dly_set(dly_set), .dly_rst(dly_rst),
        .rd_chn(rd_chn), .rd_delay(rd_delay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Entered and left on a negedge; the accept edge falls in between.
    task automatic do_write(input logic [CB-1:0] chn, input logic bc, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_chn   = chn;
        wr_bcast = bc;
        wr_delay = d;
        @(negedge clk);
        wr_valid = 1'b0;
        wr_bcast = 1'b0;
    endtask

    task automatic run_set(input string tag);
        int n;
        n = 0;
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_timeout actual=%b required=1", tag, done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; wr_valid = 0; wr_chn = 0; wr_bcast = 0; wr_delay = 0;
        set_req = 0; err_clr = 0; rd_chn = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dly_cntval !== {NCH{5'h05}}) begin failures++; $display("FAIL rst_cntval actual=%h required=%h", dly_cntval, {NCH{5'h05}}); end
        checks++;
        if (dly_ifdly !== {NCH{3'h3}}) begin failures++; $display("FAIL rst_ifdly actual=%h required=%h", dly_ifdly, {NCH{3'h3}}); end
        checks++;
        if ({dly_rst, wr_ready, busy, done, dly_set, err_fine, err_chn} !== 7'b1000000) begin
            failures++; $display("FAIL rst_ctrl actual=%b required=1000000", {dly_rst, wr_ready, busy, done, dly_set, err_fine, err_chn});
        end
        checks++;
        if (dly_ld !== '0) begin failures++; $display("FAIL rst_ld actual=%h required=0", dly_ld); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({dly_rst, wr_ready} !== 2'b10) begin failures++; $display("FAIL rel_edge1 actual=%b required=10", {dly_rst, wr_ready}); end
        @(negedge clk);
        checks++;
        if ({dly_rst, wr_ready} !== 2'b01) begin failures++; $display("FAIL rel_edge2 actual=%b required=01", {dly_rst, wr_ready}); end
        checks++;
        if (rd_delay !== (RB_EN ? 8'h2B : 8'h00)) begin failures++; $display("FAIL rst_rd actual=%h required=%h", rd_delay, RB_EN ? 8'h2B : 8'h00); end
    endtask

    task automatic test_write_set();
        int n;
        bit seen;
        do_write(3'd2, 1'b0, 8'h5C);
        checks++;
        if (dly_ld !== 6'b000100) begin failures++; $display("FAIL ws_ld actual=%b required=000100", dly_ld); end
        checks++;
        if (dly_cntval[14:10] !== 5'h0B) begin failures++; $display("FAIL ws_cnt2 actual=%h required=0b", dly_cntval[14:10]); end
        checks++;
        if (dly_cntval[9:5] !== 5'h05) begin failures++; $display("FAIL ws_cnt1 actual=%h required=05", dly_cntval[9:5]); end
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
        checks++;
        if ({dly_set, busy, dly_ifdly[8:6]} !== 5'b11_011) begin
            failures++; $display("FAIL ws_set actual=%b required=11011", {dly_set, busy, dly_ifdly[8:6]});
        end
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                checks++;
                if ({dly_set, dly_ifdly[8:6]} !== 4'b0_100) begin
                    failures++; $display("FAIL ws_apply actual=%b required=0100", {dly_set, dly_ifdly[8:6]});
                end
            end
            if (done) seen = 1;
        end
        checks++;
        if (n !== 5) begin failures++; $display("FAIL ws_done_lat actual=%0d required=5", n); end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin failures++; $display("FAIL ws_idle actual=%b required=00", {busy, done}); end
        rd_chn = 3'd2;
        @(negedge clk);
        checks++;
        if (rd_delay !== (RB_EN ? 8'h5C : 8'h00)) begin failures++; $display("FAIL ws_rd2 actual=%h required=%h", rd_delay, RB_EN ? 8'h5C : 8'h00); end
        rd_chn = 3'd6;
        @(negedge clk);
        checks++;
        if (rd_delay !== 8'h00) begin failures++; $display("FAIL ws_rd_bad actual=%h required=00", rd_delay); end
    endtask

    task automatic test_errors();
        do_write(3'd1, 1'b0, 8'h0F);
        checks++;
        if ({err_fine, dly_cntval[9:5]} !== 6'b1_00001) begin
            failures++; $display("FAIL er_fine_set actual=%b required=100001", {err_fine, dly_cntval[9:5]});
        end
        run_set("er");
        checks++;
        if (dly_ifdly[5:3] !== 3'h4) begin failures++; $display("FAIL er_clamp actual=%h required=4", dly_ifdly[5:3]); end
        rd_chn = 3'd1;
        @(negedge clk);
        checks++;
        if (rd_delay !== (RB_EN ? 8'h0C : 8'h00)) begin failures++; $display("FAIL er_rd1 actual=%h required=%h", rd_delay, RB_EN ? 8'h0C : 8'h00); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_fine !== 1'b0) begin failures++; $display("FAIL er_clr actual=%b required=0", err_fine); end
        err_clr = 1'b1;
        do_write(3'd1, 1'b0, 8'h0F);
        err_clr = 1'b0;
        checks++;
        if ({err_fine, err_chn} !== 2'b10) begin failures++; $display("FAIL er_clr_race actual=%b required=10", {err_fine, err_chn}); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_bcast();
        checks++;
        if (wr_ready !== 1'b1) begin failures++; $display("FAIL bc_ready actual=%b required=1", wr_ready); end
        do_write(3'd0, 1'b1, 8'h81);
        checks++;
        if (dly_ld !== 6'h3F) begin failures++; $display("FAIL bc_ld actual=%b required=111111", dly_ld); end
        checks++;
        if (dly_cntval !== {NCH{5'h10}}) begin failures++; $display("FAIL bc_cnt actual=%h required=%h", dly_cntval, {NCH{5'h10}}); end
        @(negedge clk);
        checks++;
        if (dly_ld !== 6'h00) begin failures++; $display("FAIL bc_ld_pulse actual=%b required=000000", dly_ld); end
        do_write(3'd6, 1'b0, 8'h28);
        checks++;
        if ({dly_ld, err_chn, busy} !== 8'b000000_1_0) begin
            failures++; $display("FAIL bad_chn actual=%b required=00000010", {dly_ld, err_chn, busy});
        end
        checks++;
        if (dly_cntval !== {NCH{5'h10}}) begin failures++; $display("FAIL bad_chn_cnt actual=%h required=%h", dly_cntval, {NCH{5'h10}}); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        wr_valid = 1'b1; wr_chn = 3'd3; wr_delay = 8'h18; set_req = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        checks++;
        if ({dly_ld, dly_set, busy} !== 8'b001000_0_0) begin
            failures++; $display("FAIL bb_write_first actual=%b required=00100000", {dly_ld, dly_set, busy});
        end
        @(negedge clk);
        checks++;
        if ({dly_set, wr_ready} !== 2'b10) begin failures++; $display("FAIL bb_set_next actual=%b required=10", {dly_set, wr_ready}); end
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL bb_done1 actual=%b required=1", done); end
        @(negedge clk);
        checks++;
        if ({busy, dly_set} !== 2'b00) begin failures++; $display("FAIL bb_idle_gap actual=%b required=00", {busy, dly_set}); end
        @(negedge clk);
        checks++;
        if ({dly_set, wr_ready} !== 2'b10) begin failures++; $display("FAIL bb_reseq actual=%b required=10", {dly_set, wr_ready}); end
        set_req = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (dly_ifdly !== {3'h1, 3'h1, 3'h0, 3'h1, 3'h1, 3'h1}) begin
            failures++; $display("FAIL bb_ifdly actual=%h required=%h", dly_ifdly, {3'h1, 3'h1, 3'h0, 3'h1, 3'h1, 3'h1});
        end
        checks++;
        if (dly_cntval[19:15] !== 5'h03) begin failures++; $display("FAIL bb_cnt3 actual=%h required=03", dly_cntval[19:15]); end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        do_write(3'd0, 1'b0, 8'hFC);
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, dly_set, done} !== 3'b100) begin failures++; $display("FAIL rm_settle actual=%b required=100", {busy, dly_set, done}); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dly_rst, wr_ready, busy, done, dly_set, err_fine, err_chn} !== 7'b1000000) begin
            failures++; $display("FAIL rm_ctrl actual=%b required=1000000", {dly_rst, wr_ready, busy, done, dly_set, err_fine, err_chn});
        end
        checks++;
        if (dly_cntval !== {NCH{5'h05}} || dly_ifdly !== {NCH{3'h3}}) begin
            failures++; $display("FAIL rm_lanes actual=%h/%h required=%h/%h", dly_cntval, dly_ifdly, {NCH{5'h05}}, {NCH{3'h3}});
        end
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        checks++;
        if (saw_done !== 1'b0) begin failures++; $display("FAIL rm_no_done actual=%b required=0", saw_done); end
        rd_chn = 3'd0;
        @(negedge clk);
        checks++;
        if (rd_delay !== (RB_EN ? 8'h2B : 8'h00)) begin failures++; $display("FAIL rm_rd0 actual=%h required=%h", rd_delay, RB_EN ? 8'h2B : 8'h00); end
        checks++;
        if ({dly_rst, wr_ready, dly_ifdly[2:0]} !== 5'b01_011) begin
            failures++; $display("FAIL rm_release actual=%b required=01011", {dly_rst, wr_ready, dly_ifdly[2:0]});
        end
    endtask

    initial begin
        test_reset();
        test_write_set();
        test_errors();
        test_bcast();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
